// File: rtl/cache_set_assoc.sv
// cache_set_assoc: one set of an N-way set-associative cache.
// Holds per-way valid/tag/data and a true-LRU age per way (age 0 = MRU,
// age WAYS-1 = LRU; ages always form a permutation of 0..WAYS-1).
// Accepts one lookup / fill / invalidate / write-hit per cycle and
// answers each with a registered response exactly one cycle later.
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   req_valid/op/tag/data request (op: 00 lookup, 01 fill, 10 inval, 11 wr-hit)
//   rsp_valid             one-cycle response pulse
//   rsp_hit/way/data      hit flag, way involved, lookup data (else 0)
//   rsp_evict/evict_tag   fill displaced a valid line, and its tag
//   stat_hits/misses      lookup hit/miss counters, saturating
//                         (present only with CACHE_SET_STATS_EN defined)
//   valid_vec             current valid bits
//
// Optional feature macro: CACHE_SET_STATS_EN
module cache_set_assoc #(
  parameter int unsigned WAYS   = 8,
  parameter int unsigned TAG_W  = 24,
  parameter int unsigned DATA_W = 256,
  localparam int unsigned AGE_W = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [AGE_W-1:0]  rsp_way,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_evict,
  output logic [TAG_W-1:0]  rsp_evict_tag,
`ifdef CACHE_SET_STATS_EN
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
`endif
  output logic [WAYS-1:0]   valid_vec
);

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_FILL   = 2'b01,
    OP_INVAL  = 2'b10,
    OP_WRHIT  = 2'b11
  } op_e;

  typedef logic [WAYS-1:0][AGE_W-1:0] age_t;

  logic [WAYS-1:0]             valid_q, valid_d;
  logic [WAYS-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [WAYS-1:0][DATA_W-1:0] data_q, data_d;
  age_t                        age_q, age_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic [AGE_W-1:0]  rsp_way_q, rsp_way_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_evict_q, rsp_evict_d;
  logic [TAG_W-1:0]  rsp_evict_tag_q, rsp_evict_tag_d;

  op_e              op;
  logic             hit_any, inv_any;
  logic [AGE_W-1:0] hit_way, inv_way, lru_way, victim;

  // Promote way w to MRU; everything younger than it ages by one.
  function automatic age_t touch(input age_t a, input logic [AGE_W-1:0] w);
    age_t r;
    r = a;
    for (int unsigned i = 0; i < WAYS; i++)
      if (a[i] < a[w]) r[i] = a[i] + 1'b1;
    r[w] = '0;
    return r;
  endfunction

  // Demote way w to LRU; everything older than it gets one step younger.
  function automatic age_t demote(input age_t a, input logic [AGE_W-1:0] w);
    age_t r;
    r = a;
    for (int unsigned i = 0; i < WAYS; i++)
      if (a[i] > a[w]) r[i] = a[i] - 1'b1;
    r[w] = '1;
    return r;
  endfunction

  assign op = op_e'(req_op);

  always_comb begin
    valid_d         = valid_q;
    tag_d           = tag_q;
    data_d          = data_q;
    age_d           = age_q;
    rsp_valid_d     = 1'b0;
    rsp_hit_d       = rsp_hit_q;
    rsp_way_d       = rsp_way_q;
    rsp_data_d      = rsp_data_q;
    rsp_evict_d     = rsp_evict_q;
    rsp_evict_tag_d = rsp_evict_tag_q;
    hit_any         = 1'b0;
    hit_way         = '0;
    inv_any         = 1'b0;
    inv_way         = '0;
    lru_way         = '0;
    victim          = '0;

    // Lowest index wins for both the hit and the free-way search.
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!hit_any && valid_q[i] && tag_q[i] == req_tag) begin
        hit_any = 1'b1;
        hit_way = AGE_W'(i);
      end
      if (!inv_any && !valid_q[i]) begin
        inv_any = 1'b1;
        inv_way = AGE_W'(i);
      end
      if (age_q[i] == AGE_W'(WAYS - 1)) lru_way = AGE_W'(i);
    end

    if (req_valid) begin
      rsp_valid_d     = 1'b1;
      rsp_hit_d       = hit_any;
      rsp_way_d       = hit_any ? hit_way : '0;
      rsp_data_d      = '0;
      rsp_evict_d     = 1'b0;
      rsp_evict_tag_d = '0;
      unique case (op)
        OP_LOOKUP: begin
          if (hit_any) begin
            rsp_data_d = data_q[hit_way];
            age_d      = touch(age_q, hit_way);
          end
        end
        OP_FILL: begin
          if (hit_any)      victim = hit_way;
          else if (inv_any) victim = inv_way;
          else begin
            victim          = lru_way;
            rsp_evict_d     = 1'b1;
            rsp_evict_tag_d = tag_q[lru_way];
          end
          valid_d[victim] = 1'b1;
          tag_d[victim]   = req_tag;
          data_d[victim]  = req_data;
          age_d           = touch(age_q, victim);
          rsp_way_d       = victim;
        end
        OP_INVAL: begin
          if (hit_any) begin
            valid_d[hit_way] = 1'b0;
            age_d            = demote(age_q, hit_way);
          end
        end
        OP_WRHIT: begin
          if (hit_any) begin
            data_d[hit_way] = req_data;
            age_d           = touch(age_q, hit_way);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q         <= '0;
      tag_q           <= '0;
      data_q          <= '0;
      for (int unsigned i = 0; i < WAYS; i++) age_q[i] <= AGE_W'(i);
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_way_q       <= '0;
      rsp_data_q      <= '0;
      rsp_evict_q     <= 1'b0;
      rsp_evict_tag_q <= '0;
    end else begin
      valid_q         <= valid_d;
      tag_q           <= tag_d;
      data_q          <= data_d;
      age_q           <= age_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_hit_q       <= rsp_hit_d;
      rsp_way_q       <= rsp_way_d;
      rsp_data_q      <= rsp_data_d;
      rsp_evict_q     <= rsp_evict_d;
      rsp_evict_tag_q <= rsp_evict_tag_d;
    end
  end

`ifdef CACHE_SET_STATS_EN
  logic [31:0] stat_hits_q, stat_misses_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else if (req_valid && op == OP_LOOKUP) begin
      if (hit_any) begin
        if (stat_hits_q != '1) stat_hits_q <= stat_hits_q + 32'd1;
      end else begin
        if (stat_misses_q != '1) stat_misses_q <= stat_misses_q + 32'd1;
      end
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`endif

  assign rsp_valid     = rsp_valid_q;
  assign rsp_hit       = rsp_hit_q;
  assign rsp_way       = rsp_way_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_evict     = rsp_evict_q;
  assign rsp_evict_tag = rsp_evict_tag_q;
  assign valid_vec     = valid_q;

endmodule

// File: doc/cache_set_assoc.md
Name: cache_set_assoc

Overview:
- Parametrised N-way set-associative cache set: per-way valid bit, tag and data block, plus true-LRU replacement state.
- Performs lookup, fill, invalidate and write-hit operations, one per cycle, each answered by a registered response one cycle later.
- Sits under the cache controller. The set index is decoded above this block, which asserts req_valid only for the selected set.

Parameters:
WAYS, 8, number of ways; power of two, 2..16
TAG_W, 24, tag width in bits
DATA_W, 256, data block width in bits
AGE_W, $clog2(WAYS), derived LRU age width; not overridden

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  operation request this cycle
req_op  input  2  00 lookup, 01 fill, 10 invalidate, 11 write-hit
req_tag  input  TAG_W  tag for the operation
req_data  input  DATA_W  write data for fill and write-hit
rsp_valid  output  1  response valid; one-cycle pulse
rsp_hit  output  1  tag matched a valid way at request time
rsp_way  output  AGE_W  way hit, filled or invalidated
rsp_data  output  DATA_W  data of the hit way (lookup); otherwise 0
rsp_evict  output  1  fill displaced a valid line with a different tag
rsp_evict_tag  output  TAG_W  tag of the displaced line
valid_vec  output  WAYS  current valid bits, combinational from state

Behaviour:
- Reset (asynchronous): all valid=0, tags=0, data=0, age[i]=i, all rsp_* outputs=0.
- Ages always form a permutation of 0..WAYS-1. Age 0 is MRU; age WAYS-1 is LRU.
- Hit detect is combinational on current state: valid[w] && tag[w]==req_tag.
  - Multiple matches cannot occur, because fill never duplicates a tag.
  - If they do occur, the lowest-index way is used.
- Touch(w), with a = age[w]: every way whose age < a increments; age[w] becomes 0; other ages are unchanged.
- Latency: exactly 1 cycle. A request in cycle N gives rsp_valid=1 in cycle N+1, with rsp_* registered. With no request, rsp_valid=0 and the other rsp_* outputs hold their last values.
- Throughput: one request per cycle, back-to-back. Request N+1 sees the state updated by request N.
- Lookup:
  - Hit: rsp_hit=1, rsp_way=w, rsp_data=data[w], Touch(w).
  - Miss: rsp_hit=0, rsp_way=0, rsp_data=0, no state change.
- Fill, victim chosen in this order:
  - (1) the hit way if req_tag is already present (rsp_hit=1; overwrite data; rsp_evict=0);
  - (2) otherwise the lowest-index invalid way;
  - (3) otherwise the way with age WAYS-1 (rsp_evict=1, rsp_evict_tag=old tag).
  - Writes tag, data and valid=1, then Touch(victim). rsp_way=victim.
- Invalidate:
  - Hit: valid[w]=0, rsp_hit=1, rsp_way=w. The age of w is set to WAYS-1; ways with age > the old age decrement.
  - Miss: rsp_hit=0, no change.
- Write-hit:
  - Hit: data[w]=req_data, Touch(w), rsp_hit=1, rsp_way=w.
  - Miss: no change, rsp_hit=0.
- rsp_evict=0 for every operation except a fill that evicts.
- A reset asserted mid-operation discards any pending response: rsp_valid=0 in the cycle after reset deasserts, unless a new request arrives.

Optional Feature:
- Macro CACHE_SET_STATS_EN.
- When defined:
  - Adds outputs stat_hits and stat_misses, each 32 bits, reset to 0.
  - Each lookup increments one counter in the cycle its response is produced.
  - Counters saturate at 0xFFFFFFFF.
  - Fill, invalidate and write-hit do not count.
- When undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset, then lookup tag 0x00ABCD -> next cycle rsp_valid=1, rsp_hit=0, rsp_data=0, valid_vec=0x00.
- Fill tags 0x10..0x17 into an empty set (WAYS=8), back-to-back -> rsp_way=0..7 in order, rsp_evict=0 each time, valid_vec=0xFF.
- After the above, lookup 0x10, then fill 0x20 -> the fill evicts way 1 (LRU): rsp_evict=1, rsp_evict_tag=0x11, rsp_way=1.
- Invalidate 0x13, then fill 0x30 -> the invalidate returns rsp_hit=1, rsp_way=3; the fill lands in way 3 with rsp_evict=0.
- Write-hit 0x14 with data 0xDEAD..., then lookup 0x14 -> rsp_hit=1, rsp_way=4, rsp_data=new data. Fill of an existing tag 0x14 -> rsp_hit=1, rsp_way=4, rsp_evict=0.
- Assert reset between a request and its response -> rsp_valid=0, all ways invalid. With CACHE_SET_STATS_EN, after 3 hits and 2 misses: stat_hits=3, stat_misses=2.
